// File: rtl/fifo_rr_arbiter.sv
// Round-robin pop arbiter: drains four input FIFOs one word per cycle and routes
// each word by its two destination MSBs to one of four output FIFO write ports.
module fifo_rr_arbiter #(
  parameter int unsigned WORD_SIZE = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           in_empty,
  input  logic [WORD_SIZE-1:0] in_data0,
  input  logic [WORD_SIZE-1:0] in_data1,
  input  logic [WORD_SIZE-1:0] in_data2,
  input  logic [WORD_SIZE-1:0] in_data3,
  input  logic [3:0]           out_almost_full,
  output logic [3:0]           in_rd,
  output logic [3:0]           out_wr,
  output logic [WORD_SIZE-1:0] out_data,
  output logic                 idle,
  output logic                 paused
);

  localparam int unsigned NCH   = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_PAUSE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, rd_sel_q, grant_idx_c, cand_c;
  logic                 grant_vld_c, pop_c, any_ready_c, blocked_c, pipe_busy_c;
  logic                 rd_pend_q, s1_valid_q;
  logic [WORD_SIZE-1:0] rd_data_c, s1_data_q;

  assign any_ready_c = ~(&in_empty);
  assign blocked_c   = |out_almost_full;
  assign pipe_busy_c = rd_pend_q | s1_valid_q;

  // Circular scan starting at the channel after the last grant.
  always_comb begin
    grant_vld_c = 1'b0;
    grant_idx_c = ptr_q;
    cand_c      = ptr_q;
    for (int unsigned i = 1; i <= NCH; i++) begin
      cand_c = ptr_q + IDX_W'(i);
      if (!grant_vld_c && !in_empty[cand_c]) begin
        grant_vld_c = 1'b1;
        grant_idx_c = cand_c;
      end
    end
  end

  // Almost-full gates the pop in the same cycle; destination is unknown before the read.
  assign pop_c = (state_q == ST_ACTIVE) && !blocked_c && grant_vld_c;
  assign in_rd = pop_c ? (NCH'(1) << grant_idx_c) : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (any_ready_c) state_d = blocked_c ? ST_PAUSE : ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (blocked_c)                         state_d = ST_PAUSE;
        else if (!any_ready_c && !pipe_busy_c) state_d = ST_IDLE;
      end
      ST_PAUSE: begin
        if (!blocked_c) begin
          if (any_ready_c)       state_d = ST_ACTIVE;
          else if (!pipe_busy_c) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read data arrives the cycle after the pop, from the channel that was granted.
  always_comb begin
    rd_data_c = in_data0;
    case (rd_sel_q)
      2'd1:    rd_data_c = in_data1;
      2'd2:    rd_data_c = in_data2;
      2'd3:    rd_data_c = in_data3;
      default: rd_data_c = in_data0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= IDX_W'(NCH - 1);
      rd_sel_q   <= '0;
      rd_pend_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      out_wr     <= '0;
      out_data   <= '0;
      idle       <= 1'b1;
      paused     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= pop_c;
      if (pop_c) begin
        ptr_q    <= grant_idx_c;
        rd_sel_q <= grant_idx_c;
      end
      s1_valid_q <= rd_pend_q;
      if (rd_pend_q) s1_data_q <= rd_data_c;
      out_wr <= s1_valid_q ? (NCH'(1) << s1_data_q[WORD_SIZE-1 -: IDX_W]) : '0;
      if (s1_valid_q) out_data <= s1_data_q;
      idle   <= (state_d == ST_IDLE);
      paused <= (state_d == ST_PAUSE);
    end
  end

endmodule
